// File: rtl/mandel_engine.sv
// Mandelbrot iteration engine: latches one addressed pixel word, iterates z <- z^2 + c
// in signed Q8.24, and returns the escape count on a valid/ready result port.
module mandel_engine #(
  parameter int unsigned ENGINE_ID    = 0,
  parameter int unsigned E_ADDR_WIDTH = 3,
  parameter int unsigned ITER_WIDTH   = 8,
  parameter int unsigned MAX_ITER     = 255
) (
  input  logic                    cclk,
  input  logic                    creset,
  input  logic                    clatch_en,
  input  logic [E_ADDR_WIDTH-1:0] cengine_addr,
  input  logic [82:0]             cword2engines,
  output logic                    cdone,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [9:0]              res_x,
  output logic [8:0]              res_y,
  output logic [ITER_WIDTH-1:0]   res_iter
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    RESULT
  } state_t;

  state_t state, state_nx;

  logic [9:0]            x_q;
  logic [8:0]            y_q;
  logic signed [31:0]    cr_q, ci_q;
  logic signed [31:0]    zr, zi, zr2, zi2, zrzi2;
  logic [ITER_WIDTH-1:0] n;

  logic signed [63:0]    p_rr, p_ii, p_ri;
  logic signed [32:0]    mag;
  logic                  accept, escape, at_limit;

  assign accept   = clatch_en && (cengine_addr == E_ADDR_WIDTH'(ENGINE_ID));
  assign at_limit = (n == ITER_WIDTH'(MAX_ITER));

  always_comb begin
    p_rr = 64'(zr) * 64'(zr);
    p_ii = 64'(zi) * 64'(zi);
    p_ri = 64'(zr) * 64'(zi);
    // squares may wrap negative after truncation; the sum is taken in 33 bits so it cannot wrap again
    mag    = {zr2[31], zr2} + {zi2[31], zi2};
    escape = (mag > 33'sh0_0400_0000);
  end

  always_ff @(posedge cclk) begin
    if (!creset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MUL;
      MUL:     state_nx = ADD;
      ADD:     if (escape || at_limit) state_nx = RESULT;
               else                    state_nx = MUL;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cdone     = (state == IDLE);
  assign res_valid = (state == RESULT);

  always_ff @(posedge cclk) begin
    if (!creset) begin
      x_q      <= '0;
      y_q      <= '0;
      cr_q     <= '0;
      ci_q     <= '0;
      zr       <= '0;
      zi       <= '0;
      zr2      <= '0;
      zi2      <= '0;
      zrzi2    <= '0;
      n        <= '0;
      res_x    <= '0;
      res_y    <= '0;
      res_iter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q  <= cword2engines[82:73];
            y_q  <= cword2engines[72:64];
            cr_q <= cword2engines[63:32];
            ci_q <= cword2engines[31:0];
            zr   <= '0;
            zi   <= '0;
            n    <= '0;
          end
        end
        MUL: begin
          zr2   <= 32'(p_rr >>> 24);
          zi2   <= 32'(p_ii >>> 24);
          zrzi2 <= 32'(p_ri >>> 23);
        end
        ADD: begin
          if (escape || at_limit) begin
            res_iter <= escape ? n : ITER_WIDTH'(MAX_ITER);
            res_x    <= x_q;
            res_y    <= y_q;
          end else begin
            zr <= zr2 - zi2 + cr_q;
            zi <= zrzi2 + ci_q;
            n  <= n + ITER_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_engine.sv
// Directed bench for mandel_engine (ENGINE_ID=2) with an arithmetic reference model
// and a negedge monitor that checks every emitted result.
module tb_mandel_engine;

  localparam int MAX = 255;

  logic        cclk = 1'b0;
  logic        creset = 1'b0;
  logic        clatch_en = 1'b0;
  logic [2:0]  cengine_addr = '0;
  logic [82:0] cword2engines = '0;
  logic        res_ready = 1'b1;
  logic        cdone, res_valid;
  logic [9:0]  res_x;
  logic [8:0]  res_y;
  logic [7:0]  res_iter;

  mandel_engine #(
    .ENGINE_ID   (2),
    .E_ADDR_WIDTH(3),
    .ITER_WIDTH  (8),
    .MAX_ITER    (MAX)
  ) dut (
    .cclk         (cclk),
    .creset       (creset),
    .clatch_en    (clatch_en),
    .cengine_addr (cengine_addr),
    .cword2engines(cword2engines),
    .cdone        (cdone),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_iter     (res_iter)
  );

  always #5 cclk = ~cclk;

  int cyc = 0;
  always @(posedge cclk) cyc++;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int x;
    int y;
    int iter;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Escape count straight from the recurrence, using wide integer arithmetic.
  function automatic int model_iter(input logic [31:0] cr_b, input logic [31:0] ci_b);
    int zr, zi, zr2, zi2, zri, cr, ci;
    zr = 0;
    zi = 0;
    cr = cr_b;
    ci = ci_b;
    for (int n = 0; n <= MAX; n++) begin
      zr2 = int'((longint'(zr) * longint'(zr)) >>> 24);
      zi2 = int'((longint'(zi) * longint'(zi)) >>> 24);
      zri = int'((longint'(zr) * longint'(zi)) >>> 23);
      if (longint'(zr2) + longint'(zi2) > 64'sd67108864) return n;
      if (n == MAX) return MAX;
      zr = zr2 - zi2 + cr;
      zi = zri + ci;
    end
    return MAX;
  endfunction

  // Result monitor: fields and latency on the rising cycle, stability while held.
  logic       prev_valid = 1'b0;
  logic [9:0] cap_x;
  logic [8:0] cap_y;
  logic [7:0] cap_iter;
  always @(negedge cclk) begin
    if (res_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_x", res_x, e.x);
        check("res_y", res_y, e.y);
        check("res_iter", res_iter, e.iter);
        check("latency", cyc - e.acc, 2 * (e.iter + 1));
      end
      cap_x    = res_x;
      cap_y    = res_y;
      cap_iter = res_iter;
    end else if (res_valid) begin
      check("hold_x", res_x, cap_x);
      check("hold_y", res_y, cap_y);
      check("hold_iter", res_iter, cap_iter);
    end
    prev_valid = res_valid;
  end

  task automatic send(input int x, input int y, input logic [31:0] cr, input logic [31:0] ci,
                      input logic [2:0] addr, input bit expect_res);
    @(negedge cclk);
    clatch_en     = 1'b1;
    cengine_addr  = addr;
    cword2engines = {x[9:0], y[8:0], cr, ci};
    @(posedge cclk);
    #1;
    if (expect_res) exp_q.push_back('{x, y, model_iter(cr, ci), cyc});
    @(negedge cclk);
    clatch_en = 1'b0;
  endtask

  task automatic wait_result(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge cclk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("result_timeout", res_valid, 1);
  endtask

  initial begin
    // Model pinned against hand-iterated points.
    check("pin_c2", model_iter(32'h0200_0000, 32'h0), 2);
    check("pin_c0", model_iter(32'h0, 32'h0), 255);
    check("pin_cm2", model_iter(32'hFE00_0000, 32'h0), 255);
    check("pin_c1", model_iter(32'h0100_0000, 32'h0), 3);
    check("pin_c1i1", model_iter(32'h0100_0000, 32'h0100_0000), 2);

    // Reset for three cycles with a latch pulse that must be ignored.
    creset = 1'b0;
    @(negedge cclk);
    clatch_en     = 1'b1;
    cengine_addr  = 3'd2;
    cword2engines = {10'd5, 9'd5, 32'h0200_0000, 32'h0};
    @(negedge cclk);
    clatch_en = 1'b0;
    @(negedge cclk);
    check("rst_cdone", cdone, 1);
    check("rst_valid", res_valid, 0);
    check("rst_iter", res_iter, 0);
    check("rst_x", res_x, 0);
    check("rst_y", res_y, 0);
    creset = 1'b1;
    @(negedge cclk);
    check("post_rst_cdone", cdone, 1);

    // Word for another engine is ignored.
    send(5, 5, 32'h0200_0000, 32'h0, 3'd1, 1'b0);
    check("wrong_addr_cdone", cdone, 1);

    // Fast escape, with a second latch while busy that must not disturb x/y.
    send(17, 33, 32'h0200_0000, 32'h0, 3'd2, 1'b1);
    check("accept_cdone", cdone, 0);
    send(777, 300, 32'h0100_0000, 32'h0, 3'd2, 1'b0);
    check("busy_cdone", cdone, 0);
    wait_result(600);
    @(negedge cclk);
    check("pulse_valid_drop", res_valid, 0);
    check("pulse_cdone", cdone, 1);
    check("after_hs_x", res_x, 17);
    check("after_hs_iter", res_iter, 2);

    // Non-escaping points, including the |z|^2 == 4.0 boundary.
    send(100, 200, 32'h0, 32'h0, 3'd2, 1'b1);
    wait_result(600);
    @(negedge cclk);
    send(639, 479, 32'hFE00_0000, 32'h0, 3'd2, 1'b1);
    wait_result(600);
    @(negedge cclk);

    // Backpressure.
    res_ready = 1'b0;
    send(123, 456, 32'h0100_0000, 32'h0100_0000, 3'd2, 1'b1);
    wait_result(600);
    repeat (20) begin
      @(negedge cclk);
      check("bp_valid", res_valid, 1);
      check("bp_cdone", cdone, 0);
    end
    res_ready = 1'b1;
    @(negedge cclk);
    check("bp_release_valid", res_valid, 0);
    check("bp_release_cdone", cdone, 1);

    send(1, 2, 32'h0100_0000, 32'h0, 3'd2, 1'b1);
    wait_result(600);
    @(negedge cclk);

    // Reset mid-iteration aborts the run.
    send(50, 60, 32'h0, 32'h0, 3'd2, 1'b1);
    repeat (9) @(negedge cclk);
    creset = 1'b0;
    exp_q.delete();
    @(negedge cclk);
    creset = 1'b1;
    check("midrst_cdone", cdone, 1);
    check("midrst_valid", res_valid, 0);
    check("midrst_iter", res_iter, 0);
    check("midrst_x", res_x, 0);
    repeat (600) @(negedge cclk);
    check("midrst_idle_cdone", cdone, 1);
    send(9, 8, 32'h0200_0000, 32'h0, 3'd2, 1'b1);
    wait_result(600);
    @(negedge cclk);

    check("all_results_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
